// File: rtl/garage_slot_tracker_pkg.sv
// Purpose: shared constants and types for the garage slot tracker slice
// Latency: n/a (declarations only)
// Backpressure: n/a
package garage_pkg;

   localparam int NUM_SLOTS_C = 6;

   // Bit positions of the lettered slots in slot_raw / slot_occ
   localparam int SLOT_A = 5;
   localparam int SLOT_B = 4;
   localparam int SLOT_C = 3;
   localparam int SLOT_D = 2;
   localparam int SLOT_E = 1;
   localparam int SLOT_F = 0;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTRY_OPEN = 2'd1,
      EXIT_OPEN  = 2'd2
   } gate_state_e;

   // Plain-vector aliases of the gate states for legacy tools and waveforms
   localparam logic [1:0] ST_IDLE       = 2'(IDLE);
   localparam logic [1:0] ST_ENTRY_OPEN = 2'(ENTRY_OPEN);
   localparam logic [1:0] ST_EXIT_OPEN  = 2'(EXIT_OPEN);

endpackage

// File: rtl/garage_slot_tracker_if.sv
// Purpose: sensor/gate/count bundle between garage I/O and the slot tracker
// Latency: n/a (wires only)
// Backpressure: none; gates are level commands, passes are 1-cycle pulses
// master = garage I/O side (drives sensors and requests), slave = tracker.
interface garage_slot_tracker_if;
   import garage_pkg::*;

   logic [NUM_SLOTS_C-1:0] slot_raw;
   logic                   entry_req;
   logic                   entry_pass;
   logic                   exit_req;
   logic                   exit_pass;
   logic [NUM_SLOTS_C-1:0] slot_occ;
   logic [2:0]             car_count;
   logic [2:0]             free_cnt;
   logic                   full;
   logic                   entry_gate_open;
   logic                   exit_gate_open;
   logic                   alarm;

   modport master (
      output slot_raw, entry_req, entry_pass, exit_req, exit_pass,
      input  slot_occ, car_count, free_cnt, full,
             entry_gate_open, exit_gate_open, alarm
   );

   modport slave (
      input  slot_raw, entry_req, entry_pass, exit_req, exit_pass,
      output slot_occ, car_count, free_cnt, full,
             entry_gate_open, exit_gate_open, alarm
   );

endinterface

// File: rtl/garage_slot_tracker_debouncer.sv
// Purpose: 2-flop synchronizer plus consecutive-sample debounce for one slot sensor
// Latency: 2 + DEBOUNCE_CYCLES cycles from a raw edge to o_occ
// Backpressure: none; free-running, one sample per cycle
// Ports: i_clk, i_rst_n (async active-low), i_raw (async sensor), o_occ (debounced).
module slot_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_occ
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_occ;
   logic [CW-1:0] r_cnt;

   // While counting, r_occ is fixed, so a toggle of the synced bit can only
   // mean a return to agreement; clearing on agreement covers the toggle case.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_occ   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_occ) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_occ <= ~r_occ;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_occ = r_occ;

endmodule

// File: rtl/garage_slot_tracker.sv
// Purpose: slot occupancy debounce, entry/exit gate handshake, car/free count and full flag
// Latency: gate opens 1 cycle after request, count updates 1 cycle after pass, slots 2+DEBOUNCE_CYCLES
// Backpressure: requests ignored while a gate is open; entry refused while full
// Ports: i_clk, i_rst_n (async active-low), bus (garage_slot_tracker_if.slave).
module garage_slot_tracker
   import garage_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GATE_TIMEOUT    = 16
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   garage_slot_tracker_if.slave bus
);

   localparam int         TW        = (GATE_TIMEOUT > 2) ? $clog2(GATE_TIMEOUT) : 1;
   localparam logic [2:0] COUNT_MAX = 3'(NUM_SLOTS_C);

   logic [NUM_SLOTS_C-1:0] w_slot_occ;

   for (genvar g = 0; g < NUM_SLOTS_C; g++) begin : g_slot
      slot_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debouncer (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_raw   (bus.slot_raw[g]),
         .o_occ   (w_slot_occ[g])
      );
   end

   logic [1:0]    r_state;
   logic [TW-1:0] r_timer;
   logic [2:0]    r_count;
   logic [2:0]    r_free;
   logic          r_full;
   logic          r_alarm;
   logic          r_entry_open;
   logic          r_exit_open;

   logic [1:0]    w_state_nxt;
   logic [TW-1:0] w_timer_nxt;
   logic [2:0]    w_count_nxt;
   logic          w_alarm_nxt;
   logic          w_expired;

   // r_timer counts completed open cycles; the last open cycle has r_timer = GATE_TIMEOUT-1
   assign w_expired = (r_timer == TW'(GATE_TIMEOUT - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer + TW'(1);
      w_count_nxt = r_count;
      w_alarm_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_timer_nxt = '0;
            if (bus.exit_req) begin
               w_state_nxt = ST_EXIT_OPEN;
            end else if (bus.entry_req && !r_full) begin
               w_state_nxt = ST_ENTRY_OPEN;
            end
         end
         ST_ENTRY_OPEN: begin
            // A pass in the expiry cycle wins over the timeout
            if (bus.entry_pass) begin
               w_state_nxt = ST_IDLE;
               w_timer_nxt = '0;
               if (r_count == COUNT_MAX) w_alarm_nxt = 1'b1;
               else                      w_count_nxt = r_count + 3'd1;
            end else if (w_expired) begin
               w_state_nxt = ST_IDLE;
               w_timer_nxt = '0;
               w_alarm_nxt = 1'b1;
            end
         end
         ST_EXIT_OPEN: begin
            if (bus.exit_pass) begin
               w_state_nxt = ST_IDLE;
               w_timer_nxt = '0;
               if (r_count == 3'd0) w_alarm_nxt = 1'b1;
               else                 w_count_nxt = r_count - 3'd1;
            end else if (w_expired) begin
               w_state_nxt = ST_IDLE;
               w_timer_nxt = '0;
               w_alarm_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_timer      <= '0;
         r_count      <= 3'd0;
         r_free       <= COUNT_MAX;
         r_full       <= 1'b0;
         r_alarm      <= 1'b0;
         r_entry_open <= 1'b0;
         r_exit_open  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_timer      <= w_timer_nxt;
         r_count      <= w_count_nxt;
         r_free       <= COUNT_MAX - w_count_nxt;
         r_full       <= (w_count_nxt == COUNT_MAX);
         r_alarm      <= w_alarm_nxt;
         r_entry_open <= (w_state_nxt == ST_ENTRY_OPEN);
         r_exit_open  <= (w_state_nxt == ST_EXIT_OPEN);
      end
   end

   assign bus.slot_occ        = w_slot_occ;
   assign bus.car_count       = r_count;
   assign bus.free_cnt        = r_free;
   assign bus.full            = r_full;
   assign bus.entry_gate_open = r_entry_open;
   assign bus.exit_gate_open  = r_exit_open;
   assign bus.alarm           = r_alarm;

endmodule

// File: tb/tb_garage_slot_tracker.sv
// Purpose: directed bench for garage_slot_tracker with an abstract per-cycle model
// Latency: n/a
// Backpressure: n/a
module tb_garage_slot_tracker;
   localparam int DEB = 4;
   localparam int TO  = 16;
   localparam int NS  = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   garage_slot_tracker_if gif ();

   garage_slot_tracker #(
      .DEBOUNCE_CYCLES (DEB),
      .GATE_TIMEOUT    (TO)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (gif.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: raw-sample history per slot, and a gate described as
   // "which gate is open and for how many cycles so far".
   logic [NS-1:0] hist [0:DEB+1];
   logic [NS-1:0] m_occ;
   int            m_mode;   // 0 none, 1 entry gate open, 2 exit gate open
   int            m_open;   // cycles the current gate has been open
   int            m_count;
   bit            m_alarm;

   task automatic model_reset();
      for (int j = 0; j < DEB + 2; j++) hist[j] = '0;
      m_occ = '0; m_mode = 0; m_open = 0; m_count = 0; m_alarm = 0;
   endtask

   // Advance the model over the next rising edge, using the inputs it will sample.
   task automatic model_step();
      bit all_diff;
      for (int j = DEB + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = gif.slot_raw;
      // The debouncer sees a sample two edges late; flip after DEB disagreeing samples in a row
      for (int b = 0; b < NS; b++) begin
         all_diff = 1;
         for (int j = 2; j < DEB + 2; j++) if (hist[j][b] == m_occ[b]) all_diff = 0;
         if (all_diff) m_occ[b] = ~m_occ[b];
      end
      m_alarm = 0;
      if (m_mode == 0) begin
         if (gif.exit_req)                      begin m_mode = 2; m_open = 1; end
         else if (gif.entry_req && m_count < NS) begin m_mode = 1; m_open = 1; end
      end else if ((m_mode == 1 && gif.entry_pass) || (m_mode == 2 && gif.exit_pass)) begin
         if (m_mode == 1) begin if (m_count == NS) m_alarm = 1; else m_count++; end
         else             begin if (m_count == 0)  m_alarm = 1; else m_count--; end
         m_mode = 0;
      end else if (m_open == TO) begin
         m_mode = 0; m_alarm = 1;
      end else begin
         m_open++;
      end
   endtask

   task automatic compare_all();
      check("slot_occ",  8'(gif.slot_occ),        8'(m_occ));
      check("car_count", 8'(gif.car_count),       8'(m_count));
      check("free_cnt",  8'(gif.free_cnt),        8'(NS - m_count));
      check("full",      8'(gif.full),            8'(m_count == NS));
      check("entry_gate",8'(gif.entry_gate_open), 8'(m_mode == 1));
      check("exit_gate", 8'(gif.exit_gate_open),  8'(m_mode == 2));
      check("alarm",     8'(gif.alarm),           8'(m_alarm));
   endtask

   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            model_reset();
            compare_all();
         end else begin
            compare_all();
            model_step();
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   int open_cycles;
   int alarm_pulses;

   initial begin
      gif.slot_raw = '0; gif.entry_req = 0; gif.entry_pass = 0;
      gif.exit_req = 0;  gif.exit_pass = 0;
      repeat (3) tick();
      check("rst car_count", 8'(gif.car_count), 8'd0);
      check("rst free_cnt",  8'(gif.free_cnt),  8'd6);
      check("rst slot_occ",  8'(gif.slot_occ),  8'h00);
      rst_n = 1;
      tick();

      // Debounce latency and glitch rejection
      gif.slot_raw = 6'b110010;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 5) check("deb before latency", 8'(gif.slot_occ), 8'h00);
         if (i == 6) check("deb at latency",     8'(gif.slot_occ), 8'h32);
      end
      gif.slot_raw = 6'b110011;
      repeat (3) tick();
      gif.slot_raw = 6'b110010;
      repeat (8) tick();
      check("deb glitch", 8'(gif.slot_occ), 8'h32);

      // Fill the garage
      for (int n = 1; n <= 6; n++) begin
         gif.entry_req = 1; tick();
         gif.entry_req = 0; gif.entry_pass = 1; tick();
         gif.entry_pass = 0;
         check("fill count", 8'(gif.car_count), 8'(n));
      end
      check("full free_cnt", 8'(gif.free_cnt), 8'd0);
      check("full flag",     8'(gif.full),     8'd1);
      gif.entry_req = 1; repeat (3) tick();
      check("entry refused", 8'(gif.entry_gate_open), 8'd0);
      gif.entry_req = 0;

      // Exit wins over entry; entry serviced right after
      gif.entry_req = 1; gif.exit_req = 1; tick();
      check("prio exit open",  8'(gif.exit_gate_open),  8'd1);
      check("prio entry shut", 8'(gif.entry_gate_open), 8'd0);
      gif.exit_req = 0; gif.exit_pass = 1; tick();
      gif.exit_pass = 0;
      check("exit count", 8'(gif.car_count), 8'd5);
      check("exit full",  8'(gif.full),      8'd0);
      tick();
      check("entry after exit", 8'(gif.entry_gate_open), 8'd1);
      gif.entry_req = 0; gif.entry_pass = 1; tick();
      gif.entry_pass = 0;
      gif.exit_req = 1; tick();
      gif.exit_req = 0; gif.exit_pass = 1; tick();
      gif.exit_pass = 0;
      check("back to 5", 8'(gif.car_count), 8'd5);

      // Timeout with no pass
      gif.entry_req = 1; tick();
      gif.entry_req = 0;
      open_cycles = 0; alarm_pulses = 0;
      for (int i = 0; i < 30; i++) begin
         if (gif.entry_gate_open) open_cycles++;
         if (gif.alarm) alarm_pulses++;
         tick();
      end
      check("timeout open cycles", 8'(open_cycles),    8'd16);
      check("timeout alarm count", 8'(alarm_pulses),   8'd1);
      check("timeout count",       8'(gif.car_count),  8'd5);

      // Pass in the final open cycle counts, no alarm
      gif.entry_req = 1; tick();
      gif.entry_req = 0;
      repeat (15) tick();
      gif.entry_pass = 1; tick();
      gif.entry_pass = 0;
      check("late pass count", 8'(gif.car_count),       8'd6);
      check("late pass alarm", 8'(gif.alarm),           8'd0);
      check("late pass gate",  8'(gif.entry_gate_open), 8'd0);
      gif.exit_req = 1; tick();
      gif.exit_req = 0; gif.exit_pass = 1; tick();
      gif.exit_pass = 0;

      // Reset in the same cycle as an entry pass
      gif.entry_req = 1; tick();
      gif.entry_req = 0; gif.entry_pass = 1; rst_n = 0;
      #1;
      check("mid rst gate",  8'(gif.entry_gate_open), 8'd0);
      check("mid rst count", 8'(gif.car_count),       8'd0);
      tick();
      gif.entry_pass = 0;
      repeat (2) tick();
      rst_n = 1;
      tick();
      check("post rst count", 8'(gif.car_count), 8'd0);
      check("post rst free",  8'(gif.free_cnt),  8'd6);

      // Exit at zero holds the count and alarms
      gif.exit_req = 1; tick();
      check("zero exit open", 8'(gif.exit_gate_open), 8'd1);
      gif.exit_req = 0; gif.exit_pass = 1; tick();
      gif.exit_pass = 0;
      check("zero exit alarm", 8'(gif.alarm),     8'd1);
      check("zero exit count", 8'(gif.car_count), 8'd0);
      tick();
      check("alarm one cycle", 8'(gif.alarm), 8'd0);
      repeat (8) tick();
      check("slots after rst", 8'(gif.slot_occ), 8'h32);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/garage_slot_tracker.md
# garage_slot_tracker

Sensor-side front end of the parking controller. It debounces the six per-slot occupancy sensors into the stable A..F occupancy vector consumed by the display flag logic. It also runs the entry/exit gate handshake and keeps the authoritative car count, free-space count and full flag. It sits between the raw garage I/O and the 7-segment display decoders.

## Interface
- NUM_SLOTS, 6, number of slots; fixed at 6 for the current garage and the display.
- DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a slot change (≥2).
- GATE_TIMEOUT, 16, cycles a gate may stay open without a pass before aborting (≥2).
- clk  in  1  single system clock; everything is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- slot_raw  in  NUM_SLOTS  raw slot sensors, 1 = car present; bit 5 = slot A … bit 0 = slot F; asynchronous to clk.
- entry_req  in  1  car waiting at the entry, level.
- entry_pass  in  1  car cleared the entry gate, 1-cycle pulse.
- exit_req  in  1  car waiting at the exit, level.
- exit_pass  in  1  car cleared the exit gate, 1-cycle pulse.
- slot_occ  out  NUM_SLOTS  debounced occupancy, same bit order as slot_raw.
- car_count  out  3  cars inside, 0..NUM_SLOTS.
- free_cnt  out  3  NUM_SLOTS − car_count.
- full  out  1  car_count == NUM_SLOTS.
- entry_gate_open  out  1  entry barrier command.
- exit_gate_open  out  1  exit barrier command.
- alarm  out  1  1-cycle pulse on timeout or count saturation.

## Operation
- Reset (async assert, sync release): slot_occ=0, car_count=0, free_cnt=6, full=0, both gates=0, alarm=0, FSM=IDLE, all counters cleared. Assertion mid-handshake closes the gate immediately and discards the pending count change.
- Synchronizer: 2-flop synchronizer on every slot_raw bit before debounce.
- Debounce: one counter per slot. When the synced bit ≠ slot_occ bit, the counter increments each cycle. It resets to 0 whenever the synced bit equals slot_occ or the synced bit toggles. On reaching DEBOUNCE_CYCLES, the slot_occ bit flips and the counter clears. Slots are independent.
- Gate FSM states and transitions:
  - IDLE: exit_req → EXIT_OPEN. Otherwise entry_req & !full → ENTRY_OPEN. If both requests are present, exit wins. entry_req while full: stay IDLE, no alarm.
  - ENTRY_OPEN: entry_gate_open=1. entry_pass → IDLE with car_count+1. Timer reaches GATE_TIMEOUT → IDLE, alarm, no count change.
  - EXIT_OPEN: exit_gate_open=1. exit_pass → IDLE with car_count−1 (at 0: hold at 0, alarm). Timeout is handled as for entry.
- Pass pulses outside the matching open state are ignored. A pass pulse in the same cycle as timeout expiry counts as a pass, with no alarm.
- car_count saturates at 0 and NUM_SLOTS. An increment at NUM_SLOTS is impossible by construction; if forced, it holds and raises alarm.
- car_count is not reconciled against slot_occ; the two are independent views.

## Timing
- All outputs are registered.
- Request sampled high at edge k → gate_open high after edge k; requests are not re-sampled while a gate is open.
- Pass sampled at edge k → gate_open low, count/free_cnt/full updated after edge k, FSM in IDLE. A new request is accepted at edge k+1 at the earliest.
- Timeout: the gate stays open exactly GATE_TIMEOUT cycles with no pass. alarm is high the cycle after the gate closes (same edge as the FSM returning to IDLE).
- Slot latency from a slot_raw edge to slot_occ: 2 (sync) + DEBOUNCE_CYCLES cycles. A glitch shorter than DEBOUNCE_CYCLES never propagates.

## Structure
- Shared package garage_pkg holds:
  - the gate FSM state enum (IDLE, ENTRY_OPEN, EXIT_OPEN);
  - NUM_SLOTS_C = 6;
  - slot index constants SLOT_A=5 … SLOT_F=0.
- Sub-module slot_debouncer is instantiated once per slot. It contains the synchronizer and counter, parameterized by DEBOUNCE_CYCLES.
- FSM, timer and counters live in the top module.

## Test plan
- Reset then idle: rst_n low 3 cycles → slot_occ=0, car_count=0, free_cnt=6, full=0, gates=0, alarm=0.
- Debounce: slot_raw=6'b110010 held 10 cycles → slot_occ=6'b110010 exactly 6 cycles after the change. A 3-cycle pulse on bit 0 → slot_occ unchanged.
- Entry fill: 6 entry_req/entry_pass handshakes → car_count 1..6, free_cnt=0, full=1. A 7th entry_req → entry_gate_open stays 0.
- Priority/exit: with car_count=6, entry_req and exit_req asserted together → exit_gate_open=1, entry_gate_open=0. exit_pass → car_count=5, full=0. Entry is then serviced the next cycle.
- Timeout: entry_req with no pass → gate open exactly 16 cycles, alarm pulses once, car_count unchanged. Pass coinciding with the last cycle → count+1, no alarm.
- Reset mid-operation: rst_n low while ENTRY_OPEN, in the same cycle as entry_pass → gate closes immediately, car_count returns to 0.
